uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Parametrised successor to the single-format 9600-8N1 UART receiver. It adds:
- configurable data width, parity and stop-bit count;
- 3-sample majority voting per bit;
- parity, framing and break detection;
- a valid/ready output with a one-word hold register and overrun flag.

It sits between the Basys 3 USB-UART bridge pin and any downstream consumer (loopback TX, command parser, FIFO).

Parameters:
- CLKS_PER_BIT, 10416: clock cycles per bit (100 MHz / 9600). Legal range 8..65535.
- DATA_BITS, 8: data bits per frame, 5..9. Transmitted LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- CNT_W, $clog2(CLKS_PER_BIT): bit-timer width (derived; do not override).

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- rx_serial  in  1  raw asynchronous serial line, idle high
- m_data  out  DATA_BITS  received word, LSB = first data bit
- m_valid  out  1  m_data/error flags valid; held until accepted
- m_ready  in  1  consumer accepts word when m_valid & m_ready
- parity_err  out  1  parity mismatch for word in m_data (0 when PARITY=0)
- frame_err  out  1  any stop bit sampled 0 for word in m_data
- overrun  out  1  one-cycle pulse: completed word dropped, hold register full
- break_det  out  1  one-cycle pulse: break condition detected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset is asynchronous (rst_n low) and acts immediately.
  - Outputs m_data = 0, m_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, break_det = 0, busy = 0.
  - Synchronizer flops reset to 1; state = IDLE.
  - Reset mid-frame abandons the frame and drops any held word.
- Input path: 2-flop synchronizer, so 2 cycles of latency. All decisions use the synchronized signal rxs.
- Bit timer:
  - cnt runs 0..CLKS_PER_BIT-1 within each bit period, then wraps to 0 at the next bit.
  - H = CLKS_PER_BIT/2 (integer divide).
  - Samples are taken at cnt = H-1, H and H+1. The bit value is the 2-of-3 majority, resolved at cnt = H+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE:
    - rxs = 0 -> START, cnt = 0.
  - START:
    - Majority 0 -> continue the bit period, then DATA.
    - Majority 1 -> IDLE (glitch). No output and no flags.
  - DATA:
    - Majority stored into bit bit_idx; bit_idx advances after each bit.
    - After bit DATA_BITS-1 -> PARITY if PARITY != 0, otherwise STOP.
  - PARITY:
    - Expected parity bit = XOR of the data bits, inverted for odd parity.
    - Mismatch sets the pending parity_err.
  - STOP:
    - Each stop bit is sampled. Any 0 sets the pending frame_err.
    - The frame completes at the cnt = H+1 resolve of the last stop bit (no wait for the end of the stop bit).
  - WAIT_HIGH:
    - Stays until rxs = 1, then IDLE.
- Completion (cycle after the last stop-bit resolve):
  - Break, i.e. all data bits 0, any parity bit 0 and first stop bit 0: pulse break_det, deliver no word, go to WAIT_HIGH.
  - Else if frame_err: deliver the word, go to WAIT_HIGH.
  - Else: deliver the word, go to IDLE.
- Deliver:
  - If the hold register is empty, or m_ready = 1 in the same cycle: load m_data/parity_err/frame_err and assert m_valid.
  - Else: pulse overrun and drop the new word. The old word and its flags are retained unchanged.
- Handshake:
  - m_valid, m_data and the flags stay stable until the m_valid & m_ready cycle.
  - m_valid drops the next cycle unless a simultaneous delivery reloads it.
  - A delivery and an accept in the same cycle keep m_valid = 1 with the new word.
- Width rules:
  - bit_idx width = $clog2(DATA_BITS).
  - The timer never exceeds CLKS_PER_BIT-1.
- Formal: assert state is always a legal encoding; assert m_data stable while m_valid & !m_ready; cover overrun and break_det.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (3-bit);
  - parity_e enum {PAR_NONE, PAR_ODD, PAR_EVEN};
  - function maj3;
  - function calc_parity.
- Sub-module uart_bit_sampler:
  - owns the bit timer;
  - takes `restart` and the live rxs;
  - emits a one-cycle `bit_strobe` with the majority `bit_val` at cnt = H+1, plus `bit_end` at CLKS_PER_BIT-1.
- The top level holds the FSM, shift register, hold register and flags.

Test Plan (CLKS_PER_BIT = 16, H = 8):
- Clean frame, 8N1:
  - Stimulus: send 0xA5 with m_ready = 1.
  - Response: one m_valid pulse, m_data = 0xA5, parity_err = frame_err = 0; busy returns to 0 within 10 bit times.
- Majority vote:
  - Stimulus: 8E1 frame 0x5A with a one-cycle inversion on bit 3 at cnt = 8.
  - Response: m_data = 0x5A, no errors.
- Parity error:
  - Stimulus: 8E1 frame 0x07 with parity bit 0 (expected 1).
  - Response: m_data = 0x07, parity_err = 1.
- Glitch rejection:
  - Stimulus: line low for 3 cycles, then high.
  - Response: no m_valid; busy = 1 for at most H+2 cycles, then 0.
- Backpressure and overrun:
  - Stimulus: m_ready = 0; send 0x11 then 0x22.
  - Response: m_data stays 0x11; overrun pulses exactly once. Raising m_ready consumes 0x11; 0x22 never appears.
- Break and reset:
  - Stimulus: hold the line low for 12 bit times.
  - Response: break_det pulses once with no m_valid; no restart until the line goes high; the next frame 0x3C is received correctly.
  - Stimulus: drive rst_n low during data bit 4.
  - Response: all outputs 0 immediately; after release, 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver: FSM state encoding,
// parity mode, 2-of-3 majority vote and parity computation.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Data is zero-extended to 9 bits by the caller; padding zeros do not affect the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_ext_sampler.sv
// Bit timer and mid-bit 3-sample majority voter. Held at cnt = 0 while restart is high.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic rxs,
  output logic bit_strobe,
  output logic bit_val,
  output logic bit_end
);

  localparam int H = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
  localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(H + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             s0_reg, s0_next;
  logic             s1_reg, s1_next;

  always_comb begin
    cnt_next = cnt_reg;
    s0_next  = s0_reg;
    s1_next  = s1_reg;
    if (restart || cnt_reg == CNT_LAST) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    if (cnt_reg == CNT_S0) s0_next = rxs;
    if (cnt_reg == CNT_S1) s1_next = rxs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      s0_reg  <= 1'b1;
      s1_reg  <= 1'b1;
    end else begin
      cnt_reg <= cnt_next;
      s0_reg  <= s0_next;
      s1_reg  <= s1_next;
    end
  end

  // Third sample is the live rxs, so the vote resolves in the same cycle as the strobe.
  assign bit_strobe = !restart && (cnt_reg == CNT_S2);
  assign bit_val    = maj3(s0_reg, s1_reg, rxs);
  assign bit_end    = !restart && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: configurable frame format, majority-voted bits,
// parity/framing/break detection and a one-word valid/ready hold register.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam parity_e          PAR_MODE  = parity_e'(2'(PARITY));

  logic sync1_reg, rxs_reg;

  rx_state_t            state_reg, state_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_pend_reg, par_pend_next;
  logic                 frm_pend_reg, frm_pend_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 stop0_reg, stop0_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 done_reg, done_next;

  logic [DATA_BITS-1:0] m_data_reg, m_data_next;
  logic                 m_valid_reg, m_valid_next;
  logic                 parity_err_reg, parity_err_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic                 break_reg, break_next;

  logic restart, bit_strobe, bit_val, bit_end, is_break;

  assign restart = (state_reg == S_IDLE) || (state_reg == S_WAIT_HIGH);

  uart_bit_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .rxs        (rxs_reg),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .bit_end    (bit_end)
  );

  assign is_break = (shift_reg == '0) && ((PAR_MODE == PAR_NONE) || !par_bit_reg) && !stop0_reg;

  always_comb begin
    state_next      = state_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    par_pend_next   = par_pend_reg;
    frm_pend_next   = frm_pend_reg;
    par_bit_next    = par_bit_reg;
    stop0_next      = stop0_reg;
    stop_idx_next   = stop_idx_reg;
    done_next       = done_reg;
    m_data_next     = m_data_reg;
    m_valid_next    = m_valid_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    overrun_next    = 1'b0;
    break_next      = 1'b0;

    if (m_valid_reg && m_ready) m_valid_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (!rxs_reg) begin
          state_next    = S_START;
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
          par_pend_next = 1'b0;
          frm_pend_next = 1'b0;
          par_bit_next  = 1'b0;
          stop0_next    = 1'b1;
          done_next     = 1'b0;
        end
      end
      S_START: begin
        if (bit_strobe && bit_val) state_next = S_IDLE;
        else if (bit_end)          state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_strobe) shift_next[bit_idx_reg] = bit_val;
        if (bit_end) begin
          if (bit_idx_reg == LAST_IDX) begin
            state_next = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_strobe) begin
          par_bit_next = bit_val;
          if (bit_val != calc_parity(9'(shift_reg), PAR_MODE)) par_pend_next = 1'b1;
        end
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (done_reg) begin
          // Completion cycle: a break delivers nothing; otherwise offer the word.
          done_next = 1'b0;
          if (is_break) begin
            break_next = 1'b1;
            state_next = S_WAIT_HIGH;
          end else begin
            state_next = frm_pend_reg ? S_WAIT_HIGH : S_IDLE;
            if (!m_valid_reg || m_ready) begin
              m_data_next     = shift_reg;
              parity_err_next = par_pend_reg;
              frame_err_next  = frm_pend_reg;
              m_valid_next    = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end
        end else begin
          if (bit_strobe) begin
            if (!bit_val) frm_pend_next = 1'b1;
            if (!stop_idx_reg) stop0_next = bit_val;
            if (stop_idx_reg == LAST_STOP) done_next = 1'b1;
          end
          if (bit_end) stop_idx_next = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_reg) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= 1'b1;
      rxs_reg        <= 1'b1;
      state_reg      <= S_IDLE;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      par_pend_reg   <= 1'b0;
      frm_pend_reg   <= 1'b0;
      par_bit_reg    <= 1'b0;
      stop0_reg      <= 1'b1;
      stop_idx_reg   <= 1'b0;
      done_reg       <= 1'b0;
      m_data_reg     <= '0;
      m_valid_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      break_reg      <= 1'b0;
    end else begin
      sync1_reg      <= rx_serial;
      rxs_reg        <= sync1_reg;
      state_reg      <= state_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      par_pend_reg   <= par_pend_next;
      frm_pend_reg   <= frm_pend_next;
      par_bit_reg    <= par_bit_next;
      stop0_reg      <= stop0_next;
      stop_idx_reg   <= stop_idx_next;
      done_reg       <= done_next;
      m_data_reg     <= m_data_next;
      m_valid_reg    <= m_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
      break_reg      <= break_next;
    end
  end

  assign m_data     = m_data_reg;
  assign m_valid    = m_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign break_det  = break_reg;
  assign busy       = (state_reg != S_IDLE);

  a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
    state_reg inside {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH});
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid_reg && !m_ready) |=> $stable(m_data_reg));
  c_overrun: cover property (@(posedge clk) disable iff (!rst_n) overrun_reg);
  c_break:   cover property (@(posedge clk) disable iff (!rst_n) break_reg);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench: one 8N1 and one 8E1 receiver at 16 clocks per bit.
module tb_uart_rx_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_n, rx_e, ready_n, ready_e;
  logic [7:0] data_n, data_e;
  logic       valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n;
  logic       valid_e, perr_e, ferr_e, ovr_e, brk_e, busy_e;

  int vec_cnt = 0;
  int err_cnt = 0;

  uart_rx_ext #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_n), .m_data(data_n), .m_valid(valid_n),
    .m_ready(ready_n), .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n),
    .break_det(brk_n), .busy(busy_n));

  uart_rx_ext #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_e), .m_data(data_e), .m_valid(valid_e),
    .m_ready(ready_e), .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e),
    .break_det(brk_e), .busy(busy_e));

  // Mid-cycle monitor: accepted words, pulse counts and busy cycles.
  int acc_n = 0, ovr_cnt_n = 0, brk_cnt_n = 0, busy_cyc_n = 0, acc_e = 0;
  logic [7:0] acc_data_n = 8'h00, acc_data_e = 8'h00;
  logic acc_perr_n = 1'b0, acc_ferr_n = 1'b0, acc_perr_e = 1'b0, acc_ferr_e = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (valid_n && ready_n) begin
      acc_n++; acc_data_n = data_n; acc_perr_n = perr_n; acc_ferr_n = ferr_n;
      $display("word n: data=%h perr=%b ferr=%b", data_n, perr_n, ferr_n);
    end
    if (valid_e && ready_e) begin
      acc_e++; acc_data_e = data_e; acc_perr_e = perr_e; acc_ferr_e = ferr_e;
      $display("word e: data=%h perr=%b ferr=%b", data_e, perr_e, ferr_e);
    end
    if (ovr_n)  ovr_cnt_n++;
    if (brk_n)  brk_cnt_n++;
    if (busy_n) busy_cyc_n++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit use_e, input logic v);
    if (use_e) rx_e = v;
    else       rx_n = v;
  endtask

  // Frame bits: start, 8 data LSB first, optional parity, one stop. glitch_bit
  // inverts that frame bit for one cycle aligned with the cnt = 8 sample.
  task automatic send_frame(input bit use_e, input logic [7:0] d, input bit par_en,
                            input logic par_val, input logic stop_val, input int glitch_bit);
    logic [10:0] bits;
    int nb;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (par_en) begin
      bits[9] = par_val; bits[10] = stop_val; nb = 11;
    end else begin
      bits[9] = stop_val; nb = 10;
    end
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        drive(use_e, bits[j] ^ ((j == glitch_bit) && (c == 9)));
      end
    end
    @(negedge clk);
    drive(use_e, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b0; ready_e = 1'b0;
    idle(3);
    vec_cnt++;
    if ({data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n} !== 14'h0) begin
      err_cnt++; $display("FAIL reset_n: got %h want 0", {data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n});
    end
    vec_cnt++;
    if ({data_e, valid_e, perr_e, ferr_e, ovr_e, brk_e, busy_e} !== 14'h0) begin
      err_cnt++; $display("FAIL reset_e: got %h want 0", {data_e, valid_e, perr_e, ferr_e, ovr_e, brk_e, busy_e});
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_clean;
    int a0;
    ready_n = 1'b1;
    a0 = acc_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    vec_cnt++;
    if (busy_n !== 1'b0) begin err_cnt++; $display("FAIL clean_busy: got %b want 0", busy_n); end
    idle(4);
    vec_cnt++;
    if (acc_n - a0 != 1) begin err_cnt++; $display("FAIL clean_count: got %0d want 1", acc_n - a0); end
    vec_cnt++;
    if (acc_data_n !== 8'hA5) begin err_cnt++; $display("FAIL clean_data: got %h want a5", acc_data_n); end
    vec_cnt++;
    if ({acc_perr_n, acc_ferr_n} !== 2'b00) begin
      err_cnt++; $display("FAIL clean_flags: got %b want 00", {acc_perr_n, acc_ferr_n});
    end
  endtask

  task automatic test_majority;
    int a0;
    ready_e = 1'b1;
    a0 = acc_e;
    send_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 4);
    idle(4);
    vec_cnt++;
    if (acc_e - a0 != 1) begin err_cnt++; $display("FAIL maj_count: got %0d want 1", acc_e - a0); end
    vec_cnt++;
    if (acc_data_e !== 8'h5A) begin err_cnt++; $display("FAIL maj_data: got %h want 5a", acc_data_e); end
    vec_cnt++;
    if ({acc_perr_e, acc_ferr_e} !== 2'b00) begin
      err_cnt++; $display("FAIL maj_flags: got %b want 00", {acc_perr_e, acc_ferr_e});
    end
  endtask

  task automatic test_parity_err;
    int a0;
    a0 = acc_e;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
    idle(4);
    vec_cnt++;
    if (acc_e - a0 != 1) begin err_cnt++; $display("FAIL par_count: got %0d want 1", acc_e - a0); end
    vec_cnt++;
    if (acc_data_e !== 8'h07) begin err_cnt++; $display("FAIL par_data: got %h want 07", acc_data_e); end
    vec_cnt++;
    if ({acc_perr_e, acc_ferr_e} !== 2'b10) begin
      err_cnt++; $display("FAIL par_flags: got %b want 10", {acc_perr_e, acc_ferr_e});
    end
  endtask

  task automatic test_framing;
    int a0;
    a0 = acc_n;
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
    idle(4);
    vec_cnt++;
    if (acc_n - a0 != 1) begin err_cnt++; $display("FAIL frm_count: got %0d want 1", acc_n - a0); end
    vec_cnt++;
    if ({acc_data_n, acc_perr_n, acc_ferr_n} !== {8'h55, 2'b01}) begin
      err_cnt++; $display("FAIL frm_word: got %h/%b want 55/01", acc_data_n, {acc_perr_n, acc_ferr_n});
    end
    idle(20);
    vec_cnt++;
    if (busy_n !== 1'b0) begin err_cnt++; $display("FAIL frm_busy: got %b want 0", busy_n); end
  endtask

  task automatic test_glitch;
    int a0, b0;
    a0 = acc_n; b0 = busy_cyc_n;
    @(negedge clk); rx_n = 1'b0;
    repeat (3) @(negedge clk);
    rx_n = 1'b1;
    idle(40);
    vec_cnt++;
    if (busy_cyc_n - b0 < 1 || busy_cyc_n - b0 > 10) begin
      err_cnt++; $display("FAIL glitch_busy_cycles: got %0d want 1..10", busy_cyc_n - b0);
    end
    vec_cnt++;
    if (acc_n - a0 != 0) begin err_cnt++; $display("FAIL glitch_count: got %0d want 0", acc_n - a0); end
    vec_cnt++;
    if (busy_n !== 1'b0) begin err_cnt++; $display("FAIL glitch_busy: got %b want 0", busy_n); end
  endtask

  task automatic test_back_to_back;
    int a0, o0;
    ready_n = 1'b0;
    a0 = acc_n; o0 = ovr_cnt_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    vec_cnt++;
    if ({valid_n, data_n} !== {1'b1, 8'h11}) begin
      err_cnt++; $display("FAIL bp_hold1: got %b/%h want 1/11", valid_n, data_n);
    end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    vec_cnt++;
    if (ovr_cnt_n - o0 != 1) begin err_cnt++; $display("FAIL bp_overrun: got %0d want 1", ovr_cnt_n - o0); end
    vec_cnt++;
    if ({valid_n, data_n} !== {1'b1, 8'h11}) begin
      err_cnt++; $display("FAIL bp_hold2: got %b/%h want 1/11", valid_n, data_n);
    end
    @(negedge clk); ready_n = 1'b1;
    idle(20);
    vec_cnt++;
    if (acc_n - a0 != 1) begin err_cnt++; $display("FAIL bp_count: got %0d want 1", acc_n - a0); end
    vec_cnt++;
    if (acc_data_n !== 8'h11) begin err_cnt++; $display("FAIL bp_data: got %h want 11", acc_data_n); end
    vec_cnt++;
    if (valid_n !== 1'b0) begin err_cnt++; $display("FAIL bp_valid: got %b want 0", valid_n); end
  endtask

  task automatic test_break;
    int a0, k0;
    a0 = acc_n; k0 = brk_cnt_n;
    @(negedge clk); rx_n = 1'b0;
    repeat (192) @(negedge clk);
    vec_cnt++;
    if (brk_cnt_n - k0 != 1) begin err_cnt++; $display("FAIL brk_pulse: got %0d want 1", brk_cnt_n - k0); end
    vec_cnt++;
    if (busy_n !== 1'b1) begin err_cnt++; $display("FAIL brk_wait: got %b want 1", busy_n); end
    rx_n = 1'b1;
    idle(32);
    vec_cnt++;
    if ({busy_n, 32'(acc_n - a0)} !== 33'h0) begin
      err_cnt++; $display("FAIL brk_idle: busy %b words %0d want 0 0", busy_n, acc_n - a0);
    end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    vec_cnt++;
    if (acc_n - a0 != 1) begin err_cnt++; $display("FAIL brk_next_count: got %0d want 1", acc_n - a0); end
    vec_cnt++;
    if ({acc_data_n, acc_ferr_n} !== {8'h3C, 1'b0}) begin
      err_cnt++; $display("FAIL brk_next_word: got %h/%b want 3c/0", acc_data_n, acc_ferr_n);
    end
  endtask

  task automatic test_reset_mid;
    int a0;
    logic [8:0] pb;
    ready_n = 1'b0;
    send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    vec_cnt++;
    if ({valid_n, data_n} !== {1'b1, 8'h99}) begin
      err_cnt++; $display("FAIL rst_held: got %b/%h want 1/99", valid_n, data_n);
    end
    pb = {8'hC3, 1'b0};
    for (int j = 0; j < 6; j++) begin
      for (int c = 0; c < ((j == 5) ? 8 : 16); c++) begin
        @(negedge clk); rx_n = pb[j];
      end
    end
    @(negedge clk); rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n} !== 14'h0) begin
      err_cnt++; $display("FAIL rst_async: got %h want 0", {data_n, valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n});
    end
    rx_n = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(5);
    ready_n = 1'b1;
    a0 = acc_n;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, -1);
    idle(4);
    vec_cnt++;
    if (acc_n - a0 != 1) begin err_cnt++; $display("FAIL rst_next_count: got %0d want 1", acc_n - a0); end
    vec_cnt++;
    if (acc_data_n !== 8'hC3) begin err_cnt++; $display("FAIL rst_next_data: got %h want c3", acc_data_n); end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_majority;
    test_parity_err;
    test_framing;
    test_glitch;
    test_back_to_back;
    test_break;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
